keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_CYCLES, default 100000: clock cycles each column is driven (1 ms at 100 MHz).
REQ-002 SHALL have parameter STABLE_FRAMES, default 5: consecutive identical scan frames required to change the debounced state.
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port row_in  input  4  keypad rows (JA[7:4]); active-low, externally pulled up.
REQ-006 SHALL have port col_out  output  4  keypad column drives (JA[3:0]); active-low, exactly one bit low at any time.
REQ-007 SHALL have port key_code  output  4  hex value of the debounced key; held until the next press.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse on each accepted press.
REQ-009 SHALL have port key_held  output  1  high while the debounced state is PRESSED.

Function
REQ-010 SHALL pass row_in through a 2-flop synchronizer before any use.
REQ-011 SHALL drive col_out = 1110, 1101, 1011, 0111 in rotation (column 0..3), each for exactly SCAN_CYCLES cycles, wrapping 3->0; one frame = 4*SCAN_CYCLES cycles.
REQ-012 SHALL sample the synchronized rows only on the last cycle of each column dwell.
REQ-013 SHALL map (column, row 0..3) to codes: col0 = 1,4,7,0; col1 = 2,5,8,F; col2 = 3,6,9,E; col3 = A,B,C,D.
REQ-014 SHALL classify each completed frame as NONE (no low row seen), ONE(code) (exactly one low bit in the whole frame) or MULTI (two or more low bits, same or different columns).
REQ-015 SHALL, at frame end, increment a stability counter when the classification (including code) equals the previous frame's; otherwise reset it to 1. The counter saturates at STABLE_FRAMES.
REQ-016 SHALL have a debounced FSM with two states, IDLE and PRESSED.
REQ-017 IDLE->PRESSED SHALL occur at the frame end where ONE(c) reaches STABLE_FRAMES; that same cycle key_code <= c, key_held <= 1, key_valid = 1 for one cycle.
REQ-018 PRESSED->IDLE SHALL occur at the frame end where NONE reaches STABLE_FRAMES; key_held <= 0, key_code unchanged, no pulse.
REQ-019 In PRESSED, a stable ONE(other code) or stable MULTI SHALL cause no change; a new press is accepted only after returning to IDLE.
REQ-020 In IDLE, stable MULTI SHALL cause no change and no pulse.
REQ-021 Holding a key SHALL produce exactly one key_valid pulse, with no auto-repeat.
REQ-022 Press-to-key_valid latency SHALL be at most (STABLE_FRAMES+1) frames + 3 cycles after row_in goes low and stays low.
REQ-023 Counters SHALL be sized with $clog2 of their parameters; col_out SHALL never show zero or more than one low bit, including across wrap-around.

Reset
REQ-024 While rst_n=0: col_out=1110, key_code=0, key_valid=0, key_held=0, FSM=IDLE, dwell counter=0, stability counter=0, previous classification=NONE, synchronizer flops=1111.
REQ-025 Reset assertion mid-frame or mid-press SHALL abort immediately (asynchronously); after release, scanning SHALL restart at column 0 with a fresh frame and no pulse emitted.

Verification (SCAN_CYCLES=4, STABLE_FRAMES=2)
REQ-026 Hold row1 low only while col_out=1101 -> exactly one key_valid pulse with key_code=5, key_held=1, within 3 frames + 3 cycles.
REQ-027 Release key 5 -> key_held falls after 2 NONE frames; key_code stays 5; no pulse.
REQ-028 Row0 toggles every frame while col0 is driven (bounce) -> no key_valid; then hold it steady -> single pulse, key_code=1.
REQ-029 Keys 1 and D pressed together -> no pulse; release D, keep 1 held -> pulse with key_code=1.
REQ-030 Hold 8, then also press 3 and release 8 while 3 stays held -> no second pulse until all keys are released for 2 frames; re-press 3 -> pulse with key_code=3.
REQ-031 Assert rst_n mid-dwell on column 2 while key 9 is held -> outputs go to reset values in the same cycle; after release, col_out=1110 and key 9 is re-accepted with a fresh pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, samples the
// synchronized rows once per column dwell, and debounces whole-frame results.
module keypad_scanner #(
    parameter int SCAN_CYCLES   = 100000,
    parameter int STABLE_FRAMES = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int SW = (STABLE_FRAMES > 0) ? $clog2(STABLE_FRAMES + 1) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [SW-1:0] STAB_MAX   = SW'(STABLE_FRAMES);

    typedef enum logic [1:0] {CLS_NONE, CLS_ONE, CLS_MULTI} cls_e;
    typedef enum logic {IDLE, PRESSED} state_e;

    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] dwell;
    logic [1:0]    col;
    logic [1:0]    acc_cnt;   // low bits seen so far this frame, saturating at 2
    logic [3:0]    acc_code;
    cls_e          prev_cls;
    logic [3:0]    prev_code;
    logic [SW-1:0] stab;
    state_e        state, state_next;

    logic          dwell_end, frame_end;
    logic [3:0]    lows;
    logic [2:0]    n_low;
    logic [1:0]    row_idx;
    logic [1:0]    hit_cnt;
    logic [3:0]    hit_code;
    cls_e          frame_cls;
    logic [3:0]    frame_code;
    logic [SW-1:0] stab_next;
    logic          accept;

    function automatic logic [3:0] code_lut(input logic [1:0] c, input logic [1:0] r);
        case ({c, r})
            4'h0: code_lut = 4'h1;
            4'h1: code_lut = 4'h4;
            4'h2: code_lut = 4'h7;
            4'h3: code_lut = 4'h0;
            4'h4: code_lut = 4'h2;
            4'h5: code_lut = 4'h5;
            4'h6: code_lut = 4'h8;
            4'h7: code_lut = 4'hF;
            4'h8: code_lut = 4'h3;
            4'h9: code_lut = 4'h6;
            4'hA: code_lut = 4'h9;
            4'hB: code_lut = 4'hE;
            4'hC: code_lut = 4'hA;
            4'hD: code_lut = 4'hB;
            4'hE: code_lut = 4'hC;
            default: code_lut = 4'hD;
        endcase
    endfunction

    // Row synchronizer; idle (pulled-up) value is all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    assign dwell_end = (dwell == DWELL_LAST);
    assign frame_end = dwell_end && (col == 2'd3);
    assign lows      = ~row_s2;
    assign n_low     = 3'(lows[0]) + 3'(lows[1]) + 3'(lows[2]) + 3'(lows[3]);

    always_comb begin
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (lows[i]) row_idx = 2'(i);
    end

    // Fold this column's sample into the running frame result.
    always_comb begin
        hit_cnt  = acc_cnt;
        hit_code = acc_code;
        if (n_low != 3'd0) begin
            if (acc_cnt == 2'd0 && n_low == 3'd1) begin
                hit_cnt  = 2'd1;
                hit_code = code_lut(col, row_idx);
            end else begin
                hit_cnt  = 2'd2;
            end
        end
    end

    always_comb begin
        frame_cls  = CLS_NONE;
        frame_code = 4'h0;
        if (hit_cnt == 2'd1) begin
            frame_cls  = CLS_ONE;
            frame_code = hit_code;
        end else if (hit_cnt != 2'd0) begin
            frame_cls  = CLS_MULTI;
        end
        if (frame_cls == prev_cls && frame_code == prev_code)
            stab_next = (stab >= STAB_MAX) ? STAB_MAX : SW'(stab + 1'b1);
        else
            stab_next = SW'(1);
    end

    // Column drive is a registered rotating zero so the pins never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell   <= '0;
            col     <= 2'd0;
            col_out <= 4'b1110;
        end else if (dwell_end) begin
            dwell   <= '0;
            col     <= col + 2'd1;
            col_out <= {col_out[2:0], col_out[3]};
        end else begin
            dwell   <= dwell + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt   <= 2'd0;
            acc_code  <= 4'h0;
            prev_cls  <= CLS_NONE;
            prev_code <= 4'h0;
            stab      <= '0;
        end else if (frame_end) begin
            acc_cnt   <= 2'd0;
            acc_code  <= 4'h0;
            prev_cls  <= frame_cls;
            prev_code <= frame_code;
            stab      <= stab_next;
        end else if (dwell_end) begin
            acc_cnt   <= hit_cnt;
            acc_code  <= hit_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Only a fully debounced NONE leaves PRESSED; other keys are ignored until then.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: if (frame_cls == CLS_ONE && stab_next == STAB_MAX) begin
                    state_next = PRESSED;
                    accept     = 1'b1;
                end
                PRESSED: if (frame_cls == CLS_NONE && stab_next == STAB_MAX)
                    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_code  <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= accept;
            if (accept) key_code <= frame_code;
        end
    end

    assign key_held = (state == PRESSED);

endmodule
